// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-add multiplier.
// Latency: n/a (types only). Backpressure: n/a.
// Holds the controller state encoding and the default operand width.
package mult_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        SHIFT,
        DONE,
        HOLD
    } state_t;

endpackage

// File: rtl/addsub_nbit.sv
// N-bit adder/subtractor: y = a + b when sub=0, y = a - b when sub=1.
// Latency: combinational, zero cycles.
// Backpressure: none; the result is valid whenever the inputs are.
module addsub_nbit #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] y
);

    logic [N-1:0] b_eff;

    // Two's-complement subtract: invert b and inject the +1 as carry-in.
    assign b_eff = b ^ {N{sub}};
    assign y     = a + b_eff + N'(sub);

endmodule

// File: rtl/mult_seq_param.sv
// Sequential WIDTH x WIDTH shift-add multiplier, signed or unsigned, product = {A,B}.
// Latency: done pulses 2*WIDTH+1 cycles after the edge that accepts a rising run.
// Backpressure: new starts are ignored while busy; HOLD waits for run to drop.
module mult_seq_param
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   S,
    input  logic               load_b,
    input  logic               run,
    input  logic               signed_mode,
    output logic [2*WIDTH-1:0] product,
    output logic               x_out,
    output logic               busy,
    output logic               done
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic             x_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] m_r;
    logic             mode_r;
    logic [CW-1:0]    cnt;
    logic             run_q;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH:0]   op_a;
    logic [WIDTH:0]   op_m;
    logic [WIDTH:0]   sum;
    logic             last_sub;

    // In signed mode the multiplier's MSB has negative weight, so the final
    // partial product is subtracted instead of added.
    assign op_a     = {mode_r & a_r[WIDTH-1], a_r};
    assign op_m     = {mode_r & m_r[WIDTH-1], m_r};
    assign last_sub = mode_r && (cnt == LAST);

    addsub_nbit #(
        .N (WIDTH + 1)
    ) u_addsub (
        .a   (op_a),
        .b   (op_m),
        .sub (last_sub),
        .y   (sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            x_r    <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            m_r    <= '0;
            mode_r <= 1'b0;
            cnt    <= '0;
            run_q  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            run_q  <= run;
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_b) begin
                        x_r <= 1'b0;
                        a_r <= '0;
                        b_r <= S;
                    end else if (run && !run_q) begin
                        x_r    <= 1'b0;
                        a_r    <= '0;
                        m_r    <= S;
                        mode_r <= signed_mode;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    if (b_r[0]) begin
                        {x_r, a_r} <= sum;
                    end
                    state <= SHIFT;
                end
                SHIFT: begin
                    // X replicates itself in signed mode (arithmetic shift),
                    // and is a consumed carry in unsigned mode.
                    {x_r, a_r, b_r} <= {mode_r & x_r, x_r, a_r, b_r[WIDTH-1:1]};
                    cnt             <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= ADD;
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= HOLD;
                end
                HOLD: begin
                    if (!run) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign product = {a_r, b_r};
    assign x_out   = x_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_mult_seq_param.sv
// Directed bench for mult_seq_param at WIDTH=8 and WIDTH=16.
module tb_mult_seq_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic [7:0]  s8;
    logic        load8, run8, sm8;
    logic [15:0] prod8;
    logic        x8, busy8, done8;

    logic [15:0] s16;
    logic        load16, run16, sm16;
    logic [31:0] prod16;
    logic        x16, busy16, done16;

    int total = 0;
    int bad   = 0;

    mult_seq_param #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .reset       (reset),
        .S           (s8),
        .load_b      (load8),
        .run         (run8),
        .signed_mode (sm8),
        .product     (prod8),
        .x_out       (x8),
        .busy        (busy8),
        .done        (done8)
    );

    mult_seq_param #(.WIDTH(16)) u_dut16 (
        .clk         (clk),
        .reset       (reset),
        .S           (s16),
        .load_b      (load16),
        .run         (run16),
        .signed_mode (sm16),
        .product     (prod16),
        .x_out       (x16),
        .busy        (busy16),
        .done        (done16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic load8_b(input logic [7:0] b, input string tag);
        @(negedge clk);
        s8    = b;
        load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        chk({tag, "_load"}, {16'h0, prod8}, {24'h0, b});
    endtask

    // Start a multiply, wait for done, check latency, product and pulse width.
    task automatic mul8(input logic [7:0] s, input logic sm, input logic [15:0] exp_p,
                        input logic tgl, input string tag);
        int dc;
        dc = 0;
        @(negedge clk);
        s8   = s;
        sm8  = sm;
        run8 = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done8) begin
                dc = c;
                break;
            end
            if (tgl) begin
                s8  = ~s8;
                sm8 = ~sm8;
            end
        end
        chk({tag, "_latency"}, dc, 17);
        chk({tag, "_product"}, {16'h0, prod8}, {16'h0, exp_p});
        @(negedge clk);
        chk({tag, "_pulse"}, {31'h0, done8}, 32'h0);
        run8 = 1'b0;
        sm8  = sm;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int pulses;
        int dc;

        reset  = 1'b1;
        s8     = 8'h0;  load8  = 1'b0; run8  = 1'b0; sm8  = 1'b0;
        s16    = 16'h0; load16 = 1'b0; run16 = 1'b0; sm16 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_product", {16'h0, prod8}, 32'h0);
        chk("rst_x",       {31'h0, x8},    32'h0);
        chk("rst_busy",    {31'h0, busy8}, 32'h0);
        chk("rst_done",    {31'h0, done8}, 32'h0);
        chk("rst_prod16",  prod16,         32'h0);

        // 7 * 59 signed
        load8_b(8'h07, "m1");
        mul8(8'h3B, 1'b1, 16'h019D, 1'b0, "m1");
        chk("m1_x", {31'h0, x8}, 32'h0);

        load8_b(8'hFF, "neg1sq");
        mul8(8'hFF, 1'b1, 16'h0001, 1'b0, "neg1sq");
        load8_b(8'hFF, "u255sq");
        mul8(8'hFF, 1'b0, 16'hFE01, 1'b0, "u255sq");
        load8_b(8'h80, "minsq");
        mul8(8'h80, 1'b1, 16'h4000, 1'b0, "minsq");

        // Operand inputs wiggle every cycle while busy
        load8_b(8'h07, "tgl");
        mul8(8'h3B, 1'b1, 16'h019D, 1'b1, "tgl");

        // run held high: exactly one done, then re-press uses low byte 0x06
        load8_b(8'h02, "hold");
        @(negedge clk);
        s8     = 8'h03;
        sm8    = 1'b1;
        run8   = 1'b1;
        pulses = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        chk("hold_pulses",  pulses,           1);
        chk("hold_busy",    {31'h0, busy8},   32'h0);
        chk("hold_product", {16'h0, prod8},   32'h0006);
        run8 = 1'b0;
        repeat (2) @(negedge clk);
        mul8(8'h03, 1'b1, 16'h0012, 1'b0, "repress");

        // load_b coinciding with a rising run wins
        load8_b(8'h05, "lbwin");
        @(negedge clk);
        s8    = 8'h09;
        load8 = 1'b1;
        run8  = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        chk("lbwin_busy",    {31'h0, busy8}, 32'h0);
        chk("lbwin_product", {16'h0, prod8}, 32'h0009);
        repeat (3) @(negedge clk);
        chk("lbwin_noretrig", {31'h0, busy8}, 32'h0);
        run8 = 1'b0;
        @(negedge clk);

        // Reset in the middle of a multiply
        load8_b(8'h07, "abort");
        @(negedge clk);
        s8   = 8'h3B;
        sm8  = 1'b1;
        run8 = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_busy_before", {31'h0, busy8}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_product", {16'h0, prod8}, 32'h0);
        chk("abort_x",       {31'h0, x8},    32'h0);
        chk("abort_busy",    {31'h0, busy8}, 32'h0);
        chk("abort_done",    {31'h0, done8}, 32'h0);
        reset = 1'b0;
        run8  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done8 || busy8) pulses++;
        end
        chk("abort_quiet", pulses, 0);
        load8_b(8'h0B, "after");
        mul8(8'h0D, 1'b0, 16'h008F, 1'b0, "after");

        // WIDTH=16 signed: -32768 * 32767
        @(negedge clk);
        s16    = 16'h8000;
        load16 = 1'b1;
        @(negedge clk);
        load16 = 1'b0;
        s16    = 16'h7FFF;
        sm16   = 1'b1;
        run16  = 1'b1;
        dc     = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done16) begin
                dc = c;
                break;
            end
        end
        chk("w16_latency", dc, 33);
        chk("w16_product", prod16, 32'hC0008000);
        run16 = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_seq_param.md
MULT_SEQ_PARAM -- requirements
Module: mult_seq_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal 4..32).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port S, input, WIDTH, multiplicand source, also load source for B.
REQ-005 SHALL have port load_b, input, 1, level; in IDLE clears X and A, loads B from S.
REQ-006 SHALL have port run, input, 1, level; a multiply starts only on a low-to-high transition.
REQ-007 SHALL have port signed_mode, input, 1; 1 selects two's-complement operands, 0 selects unsigned.
REQ-008 SHALL have port product, output, 2*WIDTH, equal to {A,B}.
REQ-009 SHALL have port x_out, output, 1, sign/carry extension bit X.
REQ-010 SHALL have port busy, output, 1, high in ADD, SHIFT, DONE.
REQ-011 SHALL have port done, output, 1, single-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, ADD, SHIFT, DONE, HOLD.
REQ-013 SHALL register run each cycle; the start condition is run=1 with the registered run=0, in IDLE only.
REQ-014 On the start condition SHALL clear X and A, keep B, latch S into internal M_reg and signed_mode into mode_reg, zero the bit counter, enter ADD.
REQ-015 In ADD with B[0]=1: counts 0..WIDTH-2 SHALL compute {X,A} = ext(A) + ext(M_reg); count WIDTH-1 SHALL subtract when mode_reg=1, add when mode_reg=0; B[0]=0 leaves X,A unchanged.
REQ-016 ext() SHALL be sign extension to WIDTH+1 when mode_reg=1, zero extension when mode_reg=0; X receives bit WIDTH of the result.
REQ-017 In SHIFT SHALL shift {X,A,B} right one bit; new X = X when mode_reg=1, 0 when mode_reg=0; increment counter; go to ADD if counter < WIDTH-1 before increment, else DONE.
REQ-018 Latency SHALL be exactly 2*WIDTH+1 cycles from the accepting edge to the cycle done=1.
REQ-019 DONE SHALL assert done for one cycle, then go to HOLD.
REQ-020 HOLD SHALL wait until run=0, then enter IDLE; run held high SHALL NOT retrigger.
REQ-021 load_b SHALL be ignored outside IDLE; if load_b and the start condition coincide in IDLE, load_b SHALL win and no multiply starts.
REQ-022 S, signed_mode changes during busy SHALL NOT affect the result.
REQ-023 The result SHALL be the exact 2*WIDTH-bit product, including -2^(WIDTH-1) squared, with no overflow.

Reset
REQ-024 reset=1 SHALL force IDLE, X=0, A=0, B=0, M_reg=0, counter=0, registered run=0, product=0, x_out=0, busy=0, done=0 at the next edge.
REQ-025 reset SHALL take priority over load_b, run and any in-flight operation; an aborted multiply SHALL NOT assert done.

Structure
REQ-026 Shared package mult_pkg SHALL hold the state enum typedef and the WIDTH default constant.
REQ-027 The WIDTH+1-bit add/subtract SHALL be a sub-module addsub_nbit with an add/sub select.
REQ-028 Target size SHALL be 120-400 RTL lines; no multiplier primitive (*) SHALL be used.

Verification
REQ-029 WIDTH=8, signed: load_b with S=0x07, run with S=0x3B -> product=0x019D, X=0, done at cycle 17.
REQ-030 WIDTH=8: B=0xFF, S=0xFF, signed -> 0x0001; unsigned -> 0xFE01; B=0x80, S=0x80, signed -> 0x4000.
REQ-031 WIDTH=8, signed: B=0x02, S=0x03, run high 100 cycles -> one done pulse; release, re-press -> multiplies low byte 0x06 by 3 -> 0x0012.
REQ-032 WIDTH=8: reset asserted at cycle 6 of a multiply -> all outputs 0 next cycle, no done, IDLE.
REQ-033 WIDTH=16, signed: B=0x8000, S=0x7FFF -> product=0xC0008000, done at cycle 33.
REQ-034 WIDTH=8: toggle S and signed_mode every cycle while busy after B=0x07, S=0x3B -> product still 0x019D.
